// File: rtl/prio_enc_pkg.sv
// Shared mode encodings and pointer arithmetic for the priority / round-robin encoder.
package prio_enc_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Next round-robin start after granting index k; wraps at width, not at 2^IDX_W.
  function automatic int unsigned ptr_next(input int unsigned k, input int unsigned width);
    return (k == width - 1) ? 0 : k + 1;
  endfunction

endpackage

// File: rtl/prio_find_first.sv
// Combinational search: first set bit of req at or above start, wrapping to bit 0.
// Zero latency; no flow control.
module prio_find_first #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [WIDTH-1:0] hi_mask;
  logic [WIDTH-1:0] hi_req;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;
  logic             hi_found;
  logic             lo_found;

  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hi_mask[i] = (i >= int'(start));
    end
  end

  assign hi_req = req & hi_mask;

  // Lowest set bit among requests at or above start.
  always_comb begin
    hi_idx   = '0;
    hi_found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!hi_found && hi_req[i]) begin
        hi_found = 1'b1;
        hi_idx   = IDX_W'(i);
      end
    end
  end

  // Wrapped case: nothing above start, so the lowest set bit overall wins.
  always_comb begin
    lo_idx   = '0;
    lo_found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!lo_found && req[i]) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(i);
      end
    end
  end

  assign found = lo_found;
  assign idx   = hi_found ? hi_idx : lo_idx;

endmodule

// File: rtl/prio_rr_enc.sv
// Registered priority encoder, fixed or round-robin; one-cycle latency.
// en=0 holds every register; no other backpressure.
module prio_rr_enc
  import prio_enc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] d,
  output logic [IDX_W-1:0] y,
  output logic [WIDTH-1:0] gnt,
  output logic             valid
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] idx;
  logic             found;

  // Fixed priority is simply a round-robin search that always starts at bit 0.
  assign start = (mode == MODE_RR) ? ptr : '0;

  prio_find_first #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_find (
    .req   (d),
    .start (start),
    .idx   (idx),
    .found (found)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y     <= '0;
      gnt   <= '0;
      valid <= 1'b0;
      ptr   <= '0;
    end else if (en) begin
      valid <= found;
      y     <= found ? idx : '0;
      gnt   <= found ? (WIDTH'(1) << idx) : '0;
      if (found && (mode == MODE_RR)) begin
        ptr <= IDX_W'(ptr_next(32'(idx), WIDTH));
      end
    end
  end

endmodule

// File: tb/tb_prio_rr_enc.sv
// Directed plus randomized checks of prio_rr_enc (WIDTH=8) against a modulo-arithmetic model.
module tb_prio_rr_enc;

  localparam int W  = 8;
  localparam int IW = 3;

  logic          clk;
  logic          rst;
  logic          en;
  logic          mode;
  logic [W-1:0]  d;
  logic [IW-1:0] y;
  logic [W-1:0]  gnt;
  logic          valid;

  int compared;
  int mismatched;

  // Reference state
  int            m_ptr;
  logic [IW-1:0] m_y;
  logic [W-1:0]  m_gnt;
  logic          m_valid;

  prio_rr_enc #(.WIDTH(W), .IDX_W(IW)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .mode  (mode),
    .d     (d),
    .y     (y),
    .gnt   (gnt),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Concurrent properties
  a_latency: assert property (@(posedge clk) disable iff (!rst)
      en |=> (valid == ($past(d) != '0)))
    else begin mismatched++; $error("FAIL latency valid=%0b", valid); end
  c_latency: cover property (@(posedge clk) disable iff (!rst) (en && d != '0) ##1 valid);

  a_idle: assert property (@(posedge clk) disable iff (!rst)
      (en && d == '0) |=> (!valid && y == '0 && gnt == '0))
    else begin mismatched++; $error("FAIL idle valid=%0b y=%0d gnt=%b", valid, y, gnt); end
  c_idle: cover property (@(posedge clk) disable iff (!rst) (en && d == '0) ##1 !valid);

  a_onehot: assert property (@(negedge clk)
      $onehot0(gnt) && (gnt == (valid ? (8'd1 << y) : 8'd0)) && (valid || y == '0))
    else begin mismatched++; $error("FAIL onehot valid=%0b y=%0d gnt=%b", valid, y, gnt); end
  c_onehot: cover property (@(negedge clk) valid && gnt[W-1]);

  a_reset: assert property (@(posedge clk)
      !rst |-> (y == '0 && gnt == '0 && !valid))
    else begin mismatched++; $error("FAIL reset_outputs y=%0d gnt=%b valid=%0b", y, gnt, valid); end
  c_reset: cover property (@(posedge clk) !rst);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_y"},     32'(y),        32'(m_y));
    check({tag, "_gnt"},   32'(gnt),      32'(m_gnt));
    check({tag, "_valid"}, 32'(valid),    32'(m_valid));
    check({tag, "_ptr"},   32'(dut.ptr),  32'(m_ptr));
  endtask

  task automatic model_reset();
    m_ptr = 0; m_y = '0; m_gnt = '0; m_valid = 1'b0;
  endtask

  // Called at a negedge: drive, let one rising edge happen, check at the next negedge.
  task automatic step(input logic e, input logic m, input logic [W-1:0] dv, input string tag);
    int  start;
    int  k;
    bit  f;
    en = e; mode = m; d = dv;
    @(posedge clk);
    if (e) begin
      f = 0; k = 0;
      start = m ? m_ptr : 0;
      for (int off = 0; off < W; off++) begin
        if (!f && dv[(start + off) % W]) begin
          f = 1;
          k = (start + off) % W;
        end
      end
      m_valid = f;
      m_y     = f ? IW'(k) : '0;
      m_gnt   = f ? (8'd1 << k) : 8'd0;
      if (f && m) m_ptr = (k + 1) % W;
    end
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] rd;
    compared = 0; mismatched = 0;
    rst = 1'b0; en = 1'b0; mode = 1'b0; d = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    rst = 1'b1;

    // Fixed priority: lowest index wins, pointer untouched.
    step(1'b1, 1'b0, 8'b1010_0100, "fixed");
    check("fixed_y_lit", 32'(y), 32'd2);
    check("fixed_gnt_lit", 32'(gnt), 32'h04);
    check("fixed_ptr_lit", 32'(dut.ptr), 32'd0);

    // Round-robin sweep with all requests set.
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, 8'hFF, "sweep");
      check("sweep_y_lit", 32'(y), 32'(i % 8));
      check("sweep_valid_lit", 32'(valid), 32'd1);
    end

    // Wrap past the top back to bit 0.
    step(1'b1, 1'b1, 8'h20, "wrap_a");
    check("wrap_a_ptr_lit", 32'(dut.ptr), 32'd6);
    step(1'b1, 1'b1, 8'b0000_0011, "wrap_b");
    check("wrap_b_y_lit", 32'(y), 32'd0);
    check("wrap_b_ptr_lit", 32'(dut.ptr), 32'd1);
    step(1'b1, 1'b1, 8'b0000_0011, "wrap_c");
    check("wrap_c_y_lit", 32'(y), 32'd1);
    check("wrap_c_ptr_lit", 32'(dut.ptr), 32'd2);

    // Idle then hold.
    step(1'b1, 1'b1, 8'h00, "idle");
    check("idle_valid_lit", 32'(valid), 32'd0);
    step(1'b1, 1'b1, 8'h08, "pre_hold");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, i[0], 8'h80, "hold");
      check("hold_y_lit", 32'(y), 32'd3);
    end

    // Request at the pointer itself wins; then a mode switch keeps the pointer.
    step(1'b1, 1'b1, 8'h11, "incl");
    check("incl_y_lit", 32'(y), 32'd4);
    step(1'b1, 1'b0, 8'hF0, "fix_after_rr");
    check("fix_after_rr_ptr_lit", 32'(dut.ptr), 32'd5);

    // Asynchronous reset mid-sweep.
    step(1'b1, 1'b1, 8'hFF, "pre_rst_a");
    step(1'b1, 1'b1, 8'hFF, "pre_rst_b");
    #2 rst = 1'b0;
    #1;
    check("async_y", 32'(y), 32'd0);
    check("async_gnt", 32'(gnt), 32'd0);
    check("async_valid", 32'(valid), 32'd0);
    check("async_ptr", 32'(dut.ptr), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 1'b1, 8'hFF, "post_rst");
    check("post_rst_y_lit", 32'(y), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       rd = '0;
        1:       rd = 8'd1 << $urandom_range(0, 7);
        default: rd = W'($urandom);
      endcase
      step($urandom_range(0, 4) != 0, 1'($urandom), rd, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
